// File: rtl/flash_byte_sequencer.sv
// Flash byte sequencer: fetches one flash word per read access over an Avalon-MM style
// master and serves its byte lanes one at a time, forward or reverse, inside a bounded
// word range with optional looping.
module flash_byte_sequencer #(
  parameter int unsigned                ADDR_WIDTH     = 23,
  parameter int unsigned                BYTES_PER_WORD = 4,
  parameter int unsigned                WORD_DELTA     = 1,
  parameter logic [ADDR_WIDTH-1:0]      START_ADDR     = '0,
  parameter logic [ADDR_WIDTH-1:0]      END_ADDR       = 'h7FFFF
) (
  input  logic                                clk,
  input  logic                                reset_n,
  input  logic                                start,
  input  logic                                restart,
  input  logic                                reverse,
  input  logic                                loop_en,
  input  logic                                byte_ready,
  output logic [7:0]                          byte_out,
  output logic                                byte_valid,
  output logic                                busy,
  output logic                                done,
  output logic [ADDR_WIDTH-1:0]               curr_word,
  output logic [$clog2(BYTES_PER_WORD)-1:0]   curr_byte,
  output logic                                flash_mem_read,
  output logic [ADDR_WIDTH-1:0]               flash_mem_address,
  input  logic                                flash_mem_waitrequest,
  input  logic                                flash_mem_readdatavalid,
  input  logic [8*BYTES_PER_WORD-1:0]         flash_mem_readdata
);

  localparam int unsigned LaneW = $clog2(BYTES_PER_WORD);
  localparam logic [LaneW-1:0]      LastLane = LaneW'(BYTES_PER_WORD - 1);
  localparam logic [ADDR_WIDTH-1:0] Delta    = ADDR_WIDTH'(WORD_DELTA);

  typedef enum logic [2:0] {StIdle, StFetch, StWaitData, StServe, StDone} state_e;

  state_e                       state_q, state_d;
  logic [ADDR_WIDTH-1:0]        word_q, word_d;
  logic [LaneW-1:0]             lane_q, lane_d;
  logic [8*BYTES_PER_WORD-1:0]  data_q, data_d;
  logic                         pend_q, pend_d;

  // State and position registers; reset abandons any outstanding access.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      word_q  <= START_ADDR;
      lane_q  <= '0;
      data_q  <= '0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      lane_q  <= lane_d;
      data_q  <= data_d;
      pend_q  <= pend_d;
    end
  end

  // Next-state, position stepping and range-edge handling.
  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    lane_d  = lane_q;
    data_d  = data_q;
    pend_d  = pend_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (restart) begin
          state_d = StIdle;
          word_d  = START_ADDR;
          lane_d  = '0;
        end else if (start) begin
          state_d = StFetch;
          word_d  = reverse ? END_ADDR : START_ADDR;
          lane_d  = reverse ? LastLane : '0;
        end
      end
      StFetch: begin
        // An in-flight request must still be accepted, so restart is only remembered.
        if (restart) pend_d = 1'b1;
        if (!flash_mem_waitrequest) state_d = StWaitData;
      end
      StWaitData: begin
        if (restart) pend_d = 1'b1;
        if (flash_mem_readdatavalid) begin
          if (restart || pend_q) begin
            state_d = StIdle;
            word_d  = START_ADDR;
            lane_d  = '0;
            pend_d  = 1'b0;
          end else begin
            data_d  = flash_mem_readdata;
            state_d = StServe;
          end
        end
      end
      StServe: begin
        if (restart) begin
          state_d = StIdle;
          word_d  = START_ADDR;
          lane_d  = '0;
        end else if (byte_ready) begin
          if (!reverse) begin
            if (lane_q != LastLane) begin
              lane_d = lane_q + LaneW'(1);
            end else if (word_q == END_ADDR) begin
              if (loop_en) begin
                word_d  = START_ADDR;
                lane_d  = '0;
                state_d = StFetch;
              end else begin
                state_d = StDone;
              end
            end else begin
              word_d  = word_q + Delta;
              lane_d  = '0;
              state_d = StFetch;
            end
          end else begin
            if (lane_q != '0) begin
              lane_d = lane_q - LaneW'(1);
            end else if (word_q == START_ADDR) begin
              if (loop_en) begin
                word_d  = END_ADDR;
                lane_d  = LastLane;
                state_d = StFetch;
              end else begin
                state_d = StDone;
              end
            end else begin
              word_d  = word_q - Delta;
              lane_d  = LastLane;
              state_d = StFetch;
            end
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs decode directly from registered state so reset clears them at once.
  always_comb begin
    byte_out          = data_q[{lane_q, 3'b000} +: 8];
    byte_valid        = (state_q == StServe);
    busy              = (state_q != StIdle) && (state_q != StDone);
    done              = (state_q == StDone);
    curr_word         = word_q;
    curr_byte         = lane_q;
    flash_mem_read    = (state_q == StFetch);
    flash_mem_address = word_q;
  end

endmodule

// File: tb/tb_flash_byte_sequencer.sv
// Bench for flash_byte_sequencer: a flash slave with random stalls and a position-level
// reference model of the byte stream (range, direction, looping) checked every cycle.
module tb_flash_byte_sequencer;

  localparam int AW  = 8;
  localparam int BPW = 4;
  localparam int ST  = 2;
  localparam int EN  = 5;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          start, restart, reverse, loop_en, byte_ready;
  logic [7:0]    byte_out;
  logic          byte_valid, busy, done;
  logic [AW-1:0] curr_word;
  logic [1:0]    curr_byte;
  logic          flash_mem_read;
  logic [AW-1:0] flash_mem_address;
  logic          flash_mem_waitrequest;
  logic          flash_mem_readdatavalid;
  logic [31:0]   flash_mem_readdata;

  always #5 clk = ~clk;

  flash_byte_sequencer #(
    .ADDR_WIDTH    (AW),
    .BYTES_PER_WORD(BPW),
    .WORD_DELTA    (1),
    .START_ADDR    (8'(ST)),
    .END_ADDR      (8'(EN))
  ) dut (
    .clk                    (clk),
    .reset_n                (reset_n),
    .start                  (start),
    .restart                (restart),
    .reverse                (reverse),
    .loop_en                (loop_en),
    .byte_ready             (byte_ready),
    .byte_out               (byte_out),
    .byte_valid             (byte_valid),
    .busy                   (busy),
    .done                   (done),
    .curr_word              (curr_word),
    .curr_byte              (curr_byte),
    .flash_mem_read         (flash_mem_read),
    .flash_mem_address      (flash_mem_address),
    .flash_mem_waitrequest  (flash_mem_waitrequest),
    .flash_mem_readdatavalid(flash_mem_readdatavalid),
    .flash_mem_readdata     (flash_mem_readdata)
  );

  int tests = 0;
  int fails = 0;

  // Flash contents: a fixed pattern per word address.
  function automatic logic [31:0] mem_word(input int w);
    logic [31:0] r;
    for (int k = 0; k < 4; k++) r[8*k +: 8] = 8'((w * 37 + k * 71 + 13) % 256);
    return r;
  endfunction

  function automatic logic [7:0] exp_byte(input int w, input int k);
    logic [31:0] m;
    m = mem_word(w);
    return m[8*k +: 8];
  endfunction

  // Flash slave: random stall per access, readdatavalid one cycle after acceptance.
  int   wait_lo, wait_hi, wait_left, accepts;
  bit   in_acc, acc_pend;
  int   acc_addr;
  always @(negedge clk) begin
    if (!reset_n) begin
      in_acc = 0; acc_pend = 0; wait_left = 0;
      flash_mem_waitrequest = 1'b0;
      flash_mem_readdatavalid = 1'b0;
      flash_mem_readdata = '0;
    end else begin
      flash_mem_readdatavalid = acc_pend;
      flash_mem_readdata = acc_pend ? mem_word(acc_addr) : $urandom;
      acc_pend = 0;
      if (flash_mem_read) begin
        if (!in_acc) begin
          in_acc = 1;
          wait_left = $urandom_range(wait_hi, wait_lo);
        end
        if (wait_left > 0) begin
          flash_mem_waitrequest = 1'b1;
          wait_left--;
        end else begin
          flash_mem_waitrequest = 1'b0;
          in_acc = 0;
          acc_pend = 1;
          acc_addr = int'(flash_mem_address);
          accepts++;
        end
      end else begin
        flash_mem_waitrequest = 1'b0;
      end
    end
  end

  // Reference model: position of the next byte to be served.
  int mw, mk, m_xfers, stall_cnt;
  bit m_active, m_done;

  task automatic m_reset();
    m_active = 0; m_done = 0; mw = ST; mk = 0; stall_cnt = 0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic advance();
    m_xfers++;
    if (!reverse) begin
      if (mk != BPW - 1) mk++;
      else if (mw == EN) begin
        if (loop_en) begin mw = ST; mk = 0; end
        else begin m_active = 0; m_done = 1; end
      end else begin mw++; mk = 0; end
    end else begin
      if (mk != 0) mk--;
      else if (mw == ST) begin
        if (loop_en) begin mw = EN; mk = BPW - 1; end
        else begin m_active = 0; m_done = 1; end
      end else begin mw--; mk = BPW - 1; end
    end
  endtask

  // Apply the model for the coming clock edge, then check at the following negedge.
  task automatic step();
    if (!m_active) begin
      if (restart) m_done = 0;
      else if (start) begin
        m_active = 1; m_done = 0;
        if (reverse) begin mw = EN; mk = BPW - 1; end
        else begin mw = ST; mk = 0; end
      end
    end else if (byte_valid && byte_ready) begin
      advance();
    end
    tick();
    chk("done", done, m_done);
    chk("busy", busy, m_active);
    if (!m_active) chk("valid_idle", byte_valid, 0);
    if (byte_valid) begin
      chk("byte_out", byte_out, exp_byte(mw, mk));
      chk("curr_byte", curr_byte, mk);
      chk("curr_word", curr_word, mw);
    end
    if (flash_mem_read) chk("read_addr", flash_mem_address, mw);
    if (m_active && !byte_valid) stall_cnt++;
    else stall_cnt = 0;
    if (stall_cnt > 40) begin
      chk("progress_timeout", stall_cnt, 0);
      stall_cnt = 0;
    end
  endtask

  task automatic run_until_xfers(input int n, input int budget);
    int target;
    int first;
    first = m_xfers;
    target = m_xfers + n;
    for (int i = 0; i < budget && m_xfers < target; i++) step();
    chk("xfer_count", m_xfers - first, n);
  endtask

  task automatic run_until_done(input int budget);
    for (int i = 0; i < budget && !done; i++) step();
    chk("reach_done", done, 1);
    chk("done_no_valid", byte_valid, 0);
  endtask

  task automatic do_reset();
    reset_n = 0; start = 0; restart = 0;
    m_reset();
    tick(); tick();
    #2 reset_n = 1;
    tick();
  endtask

  initial begin
    int rd_cycles;
    int acc0;
    int a0;
    reset_n = 0; start = 0; restart = 0; reverse = 0; loop_en = 0; byte_ready = 0;
    wait_lo = 0; wait_hi = 0; accepts = 0; m_xfers = 0;
    m_reset();
    tick(); tick();
    chk("rst_valid", byte_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_read", flash_mem_read, 0);
    chk("rst_byte", byte_out, 0);
    chk("rst_word", curr_word, ST);
    chk("rst_lane", curr_byte, 0);
    #2 reset_n = 1;
    tick();

    // Forward word: latency, lane order, next read address.
    byte_ready = 1;
    start = 1; step(); start = 0;
    chk("t1_read", flash_mem_read, 1);
    chk("t1_lat1", byte_valid, 0);
    step();
    chk("t1_lat2", byte_valid, 0);
    step();
    chk("t1_lat3", byte_valid, 1);
    run_until_xfers(4, 20);
    chk("t1_next_read", flash_mem_read, 1);
    chk("t1_next_addr", flash_mem_address, ST + 1);

    // Reverse from the end of the range.
    do_reset();
    reverse = 1;
    start = 1; step(); start = 0;
    run_until_xfers(4, 20);
    chk("t2_next_read", flash_mem_read, 1);
    chk("t2_next_addr", flash_mem_address, EN - 1);

    // Looping over the whole range, then stop at the edge.
    do_reset();
    reverse = 0; loop_en = 1;
    start = 1; step(); start = 0;
    run_until_xfers(4 * (EN - ST + 1), 200);
    chk("t3_wrap_read", flash_mem_read, 1);
    chk("t3_wrap_addr", flash_mem_address, ST);
    loop_en = 0;
    run_until_done(200);

    // Stalled request stays stable and is accepted exactly once.
    do_reset();
    wait_lo = 3; wait_hi = 3; byte_ready = 0; reverse = 1;
    acc0 = accepts;
    start = 1; step(); start = 0;
    rd_cycles = 0;
    a0 = int'(flash_mem_address);
    for (int i = 0; i < 10; i++) begin
      if (flash_mem_read) begin
        rd_cycles++;
        chk("t4_addr_stable", flash_mem_address, a0);
      end
      step();
    end
    chk("t4_read_cycles", rd_cycles, 4);
    chk("t4_accepts", accepts - acc0, 1);

    // Restart while waiting for data: data drained, no byte served.
    do_reset();
    wait_lo = 0; wait_hi = 0; byte_ready = 1; reverse = 1;
    start = 1; step(); start = 0;
    step();
    chk("t5_wait_read", flash_mem_read, 0);
    restart = 1;
    m_reset();
    step();
    restart = 0;
    chk("t5_valid", byte_valid, 0);
    chk("t5_word", curr_word, ST);
    step();
    chk("t5_valid2", byte_valid, 0);

    // Restart during a stalled fetch: request held until accepted, then idle.
    do_reset();
    wait_lo = 2; wait_hi = 2; reverse = 1;
    start = 1; step(); start = 0;
    restart = 1; tick(); restart = 0;
    chk("t5b_read_held", flash_mem_read, 1);
    chk("t5b_addr_held", flash_mem_address, EN);
    for (int i = 0; i < 12 && busy; i++) begin
      chk("t5b_no_valid", byte_valid, 0);
      tick();
    end
    chk("t5b_idle", busy, 0);
    chk("t5b_word", curr_word, ST);
    chk("t5b_valid", byte_valid, 0);
    m_reset();

    // Asynchronous reset mid-serve, then resume from the range start.
    do_reset();
    wait_lo = 0; wait_hi = 0; reverse = 0; byte_ready = 1;
    start = 1; step(); start = 0;
    run_until_xfers(5, 40);
    byte_ready = 0;
    step();
    chk("t6_pre_valid", byte_valid, 1);
    chk("t6_pre_word", curr_word, ST + 1);
    #2 reset_n = 0;
    #1;
    chk("t6_valid", byte_valid, 0);
    chk("t6_busy", busy, 0);
    chk("t6_byte", byte_out, 0);
    chk("t6_read", flash_mem_read, 0);
    chk("t6_word", curr_word, ST);
    chk("t6_lane", curr_byte, 0);
    m_reset();
    tick(); tick();
    #2 reset_n = 1;
    tick();
    byte_ready = 1;
    start = 1; step(); start = 0;
    run_until_xfers(2, 20);

    // Randomised run: stalls, back-pressure, direction flips, stray start pulses.
    do_reset();
    wait_lo = 0; wait_hi = 2; loop_en = 1;
    reverse = 1'($urandom_range(0, 1));
    start = 1; step(); start = 0;
    for (int i = 0; i < 600; i++) begin
      byte_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 15) == 0) reverse = ~reverse;
      start = ($urandom_range(0, 31) == 0);
      step();
    end
    start = 0;
    loop_en = 0;
    for (int i = 0; i < 400 && !done; i++) begin
      byte_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    chk("rand_done", done, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
